// File: rtl/sr_recirc_word.sv
// Word-wide shift register that can shift in, recirculate or hold, with a
// position counter and an aligned full-word load sequencer.
module sr_recirc_word #(
  parameter int WIDTH  = 4,
  parameter int LENGTH = 8,
  localparam int PW    = ($clog2(LENGTH) < 1) ? 1 : $clog2(LENGTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic             clear,
  input  logic             load_start,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [PW-1:0]    pos,
  output logic             word_sync,
  output logic             busy,
  output logic             data_req
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    LOAD  = 2'd2
  } state_t;

  localparam logic [PW-1:0] POS_LAST = PW'(LENGTH - 1);

  logic [LENGTH-1:0][WIDTH-1:0] stage_q, stage_d;
  logic [PW-1:0]                pos_q, pos_d;
  logic                         word_sync_q, word_sync_d;
  state_t                       state_q, state_d;

  logic                         step;
  logic [WIDTH-1:0]             stage0_src;

  always_comb begin
    stage_d     = stage_q;
    pos_d       = pos_q;
    word_sync_d = 1'b0;
    state_d     = state_q;
    step        = 1'b0;
    stage0_src  = stage_q[LENGTH-1];

    if (clear) begin
      stage_d = '0;
      pos_d   = '0;
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (mode == 2'b01) begin
            step       = 1'b1;
            stage0_src = data_in;
          end else if (mode == 2'b10) begin
            step       = 1'b1;
            stage0_src = stage_q[LENGTH-1];
          end
          if (load_start) state_d = ARMED;
        end
        // Spin the ring until the word boundary so the load starts at pos 0.
        ARMED: begin
          step       = 1'b1;
          stage0_src = stage_q[LENGTH-1];
          if (pos_q == POS_LAST) state_d = LOAD;
        end
        LOAD: begin
          step       = 1'b1;
          stage0_src = data_in;
          if (pos_q == POS_LAST) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase

      if (step) begin
        for (int i = LENGTH - 1; i > 0; i--) stage_d[i] = stage_q[i-1];
        stage_d[0]  = stage0_src;
        pos_d       = (pos_q == POS_LAST) ? '0 : pos_q + PW'(1);
        word_sync_d = (pos_q == POS_LAST);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q     <= '0;
      pos_q       <= '0;
      word_sync_q <= 1'b0;
      state_q     <= IDLE;
    end else begin
      stage_q     <= stage_d;
      pos_q       <= pos_d;
      word_sync_q <= word_sync_d;
      state_q     <= state_d;
    end
  end

  assign data_out  = stage_q[LENGTH-1];
  assign pos       = pos_q;
  assign word_sync = word_sync_q;
  assign busy      = (state_q != IDLE);
  assign data_req  = (state_q == LOAD);

endmodule

// File: tb/tb_sr_recirc_word.sv
// Directed bench for sr_recirc_word at WIDTH=4, LENGTH=8.
module tb_sr_recirc_word;

  logic       clk;
  logic       reset;
  logic [1:0] mode;
  logic       clear;
  logic       load_start;
  logic [3:0] data_in;
  logic [3:0] data_out;
  logic [2:0] pos;
  logic       word_sync;
  logic       busy;
  logic       data_req;

  int checks   = 0;
  int failures = 0;

  sr_recirc_word #(.WIDTH(4), .LENGTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .clear     (clear),
    .load_start(load_start),
    .data_in   (data_in),
    .data_out  (data_out),
    .pos       (pos),
    .word_sync (word_sync),
    .busy      (busy),
    .data_req  (data_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; mode = 2'b00; clear = 1'b0; load_start = 1'b0; data_in = 4'h0;
    #12;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (data_out !== 4'h0) begin failures++; $display("FAIL reset_data_out got=%0h exp=0", data_out); end
    checks++; if (pos !== 3'd0) begin failures++; $display("FAIL reset_pos got=%0d exp=0", pos); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (word_sync !== 1'b0) begin failures++; $display("FAIL reset_word_sync got=%b exp=0", word_sync); end
    checks++; if (data_req !== 1'b0) begin failures++; $display("FAIL reset_data_req got=%b exp=0", data_req); end
  endtask

  task automatic test_shift_recirc();
    mode = 2'b01;
    for (int i = 1; i <= 8; i++) begin
      data_in = 4'(i);
      tick();
      checks++; if (pos !== 3'(i % 8)) begin failures++; $display("FAIL shift_pos step=%0d got=%0d exp=%0d", i, pos, i % 8); end
      checks++; if (word_sync !== (i == 8)) begin failures++; $display("FAIL shift_word_sync step=%0d got=%b exp=%b", i, word_sync, (i == 8)); end
    end
    checks++; if (data_out !== 4'd1) begin failures++; $display("FAIL shift_data_out got=%0h exp=1", data_out); end
    mode = 2'b10; data_in = 4'hF;
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++; if (data_out !== 4'(((k + 1) % 8) + 1)) begin failures++; $display("FAIL recirc_data_out k=%0d got=%0h exp=%0h", k, data_out, ((k + 1) % 8) + 1); end
      checks++; if (word_sync !== (k == 7)) begin failures++; $display("FAIL recirc_word_sync k=%0d got=%b exp=%b", k, word_sync, (k == 7)); end
    end
    checks++; if (pos !== 3'd0) begin failures++; $display("FAIL recirc_pos_wrap got=%0d exp=0", pos); end
  endtask

  task automatic test_hold();
    mode = 2'b10;
    repeat (3) tick();
    mode = 2'b00;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) mode = 2'b11;
      tick();
      checks++; if (pos !== 3'd3) begin failures++; $display("FAIL hold_pos k=%0d got=%0d exp=3", k, pos); end
      checks++; if (data_out !== 4'd4) begin failures++; $display("FAIL hold_data_out k=%0d got=%0h exp=4", k, data_out); end
      checks++; if (word_sync !== 1'b0) begin failures++; $display("FAIL hold_word_sync k=%0d got=%b exp=0", k, word_sync); end
    end
  endtask

  task automatic test_aligned_load();
    mode = 2'b00; load_start = 1'b1;
    tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL arm_busy got=%b exp=1", busy); end
    checks++; if (pos !== 3'd3) begin failures++; $display("FAIL arm_pos got=%0d exp=3", pos); end
    checks++; if (data_req !== 1'b0) begin failures++; $display("FAIL arm_data_req got=%b exp=0", data_req); end
    // Mode and data_in must not matter while armed.
    mode = 2'b01; data_in = 4'h0;
    for (int j = 1; j <= 5; j++) begin
      tick();
      checks++; if (pos !== 3'((3 + j) % 8)) begin failures++; $display("FAIL armed_pos j=%0d got=%0d exp=%0d", j, pos, (3 + j) % 8); end
      checks++; if (data_out !== 4'(((3 + j) % 8) + 1)) begin failures++; $display("FAIL armed_data_out j=%0d got=%0h exp=%0h", j, data_out, ((3 + j) % 8) + 1); end
      checks++; if (data_req !== (j == 5)) begin failures++; $display("FAIL armed_data_req j=%0d got=%b exp=%b", j, data_req, (j == 5)); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL armed_busy j=%0d got=%b exp=1", j, busy); end
    end
    checks++; if (word_sync !== 1'b1) begin failures++; $display("FAIL armed_word_sync got=%b exp=1", word_sync); end
    mode = 2'b00;
    for (int j = 0; j < 8; j++) begin
      checks++; if (data_req !== 1'b1) begin failures++; $display("FAIL load_data_req j=%0d got=%b exp=1", j, data_req); end
      data_in = 4'(8 + j);
      tick();
    end
    load_start = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL load_done_busy got=%b exp=0", busy); end
    checks++; if (data_req !== 1'b0) begin failures++; $display("FAIL load_done_data_req got=%b exp=0", data_req); end
    checks++; if (pos !== 3'd0) begin failures++; $display("FAIL load_done_pos got=%0d exp=0", pos); end
    checks++; if (word_sync !== 1'b1) begin failures++; $display("FAIL load_done_word_sync got=%b exp=1", word_sync); end
    checks++; if (data_out !== 4'h8) begin failures++; $display("FAIL load_done_data_out got=%0h exp=8", data_out); end
    mode = 2'b10;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++; if (data_out !== 4'(8 + (k % 8))) begin failures++; $display("FAIL load_recirc k=%0d got=%0h exp=%0h", k, data_out, 8 + (k % 8)); end
    end
  endtask

  task automatic test_clear_mid_load();
    mode = 2'b00; load_start = 1'b1;
    tick();
    load_start = 1'b0;
    repeat (8) tick();
    checks++; if (data_req !== 1'b1) begin failures++; $display("FAIL clr_entered_load got=%b exp=1", data_req); end
    data_in = 4'h5;
    repeat (3) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (data_out !== 4'h0) begin failures++; $display("FAIL clr_data_out got=%0h exp=0", data_out); end
    checks++; if (pos !== 3'd0) begin failures++; $display("FAIL clr_pos got=%0d exp=0", pos); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL clr_busy got=%b exp=0", busy); end
    checks++; if (data_req !== 1'b0) begin failures++; $display("FAIL clr_data_req got=%b exp=0", data_req); end
    checks++; if (word_sync !== 1'b0) begin failures++; $display("FAIL clr_word_sync got=%b exp=0", word_sync); end
    mode = 2'b10;
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++; if (data_out !== 4'h0) begin failures++; $display("FAIL clr_stage_zero k=%0d got=%0h exp=0", k, data_out); end
    end
    mode = 2'b01; data_in = 4'h6; clear = 1'b1; load_start = 1'b1;
    tick();
    clear = 1'b0; load_start = 1'b0; mode = 2'b00;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL clr_and_load_busy got=%b exp=0", busy); end
    checks++; if (pos !== 3'd0) begin failures++; $display("FAIL clr_and_load_pos got=%0d exp=0", pos); end
  endtask

  task automatic test_async_reset();
    mode = 2'b01; data_in = 4'h7;
    repeat (8) tick();
    checks++; if (data_out !== 4'h7) begin failures++; $display("FAIL areset_fill got=%0h exp=7", data_out); end
    mode = 2'b00; load_start = 1'b1;
    tick();
    load_start = 1'b0;
    repeat (2) tick();
    checks++; if (pos !== 3'd2 || busy !== 1'b1) begin failures++; $display("FAIL areset_pre pos=%0d busy=%b exp pos=2 busy=1", pos, busy); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (data_out !== 4'h0) begin failures++; $display("FAIL areset_data_out got=%0h exp=0", data_out); end
    checks++; if (pos !== 3'd0) begin failures++; $display("FAIL areset_pos got=%0d exp=0", pos); end
    checks++; if (busy !== 1'b0 || data_req !== 1'b0 || word_sync !== 1'b0) begin failures++; $display("FAIL areset_ctrl busy=%b data_req=%b word_sync=%b exp all 0", busy, data_req, word_sync); end
    mode = 2'b01;
    tick();
    checks++; if (pos !== 3'd0 || data_out !== 4'h0) begin failures++; $display("FAIL areset_held pos=%0d data_out=%0h exp 0,0", pos, data_out); end
    @(negedge clk);
    reset = 1'b0; mode = 2'b00;
    tick();
    checks++; if (busy !== 1'b0 || pos !== 3'd0) begin failures++; $display("FAIL areset_release busy=%b pos=%0d exp 0,0", busy, pos); end
    mode = 2'b01; data_in = 4'h3;
    tick();
    checks++; if (pos !== 3'd1) begin failures++; $display("FAIL areset_resume pos=%0d exp=1", pos); end
  endtask

  initial begin
    test_reset();
    test_shift_recirc();
    test_hold();
    test_aligned_load();
    test_clear_mid_load();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
